// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between the fetch (IF) and data (D) ports,
// with a READ_LAT-deep tag pipeline that routes each read response back to its issuer.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    owner_e              last_owner_q, last_owner_d;
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [READ_LAT-1:0] own_q, own_d;   // per-stage owner, 1 = D

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (last_owner_q == OWN_IF) d_gnt  = 1'b1;
                else                        if_gnt = 1'b1;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (d_gnt)       last_owner_d = OWN_D;
        else if (if_gnt) last_owner_d = OWN_IF;

        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = mem_en & ~mem_we;
        own_d[0] = d_gnt;
        // Flush only kills tags already in flight; the stage-0 entry loaded this cycle survives.
        for (int unsigned i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~(if_flush & ~own_q[i-1]);
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_IF;
            vld_q        <= '0;
            own_q        <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            vld_q        <= vld_d;
            own_q        <= own_d;
        end
    end

    always_comb begin
        if_rvalid = vld_q[READ_LAT-1] & ~own_q[READ_LAT-1];
        d_rvalid  = vld_q[READ_LAT-1] &  own_q[READ_LAT-1];
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: BRAM model driven by the DUT, plus a queue-based reference model
// of grants and scheduled responses that each test compares against every cycle.
module tb_mem_port_arbiter;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM, word-indexed by addr[9:2]; garbage on the read bus when not reading.
    logic [31:0] bram [256];
    logic [31:0] rpipe [RL];
    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr[9:2]] <= mem_wdata;
        rpipe[0] <= (mem_en && !mem_we) ? bram[mem_addr[9:2]] : $urandom;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RL-1];

    // Reference model: responses are queued with the cycle they are due in.
    typedef struct {
        int          due;
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] ref_mem [256];
    bit          m_last_d;
    int          cyc;
    int          total, bad;

    logic        e_if_gnt, e_d_gnt, e_en, e_we, e_if_rv, e_d_rv;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_d_rd;

    logic [133:0] obs;
    assign obs = {if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, if_rdata, d_rvalid, d_rdata};

    function automatic logic [133:0] exp_vec();
        return {e_if_gnt, e_d_gnt, e_en, e_we, e_addr, e_wdata, e_if_rv, e_if_rd, e_d_rv, e_d_rd};
    endfunction

    task automatic model_eval();
        e_if_gnt = 1'b0;
        e_d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                e_d_gnt  = !m_last_d;
                e_if_gnt = m_last_d;
            end else begin
                e_if_gnt = if_req;
                e_d_gnt  = d_req;
            end
        end
        e_en    = e_if_gnt || e_d_gnt;
        e_we    = e_d_gnt && d_we;
        e_addr  = e_d_gnt ? d_addr : (e_if_gnt ? if_addr : 32'h0);
        e_wdata = e_d_gnt ? d_wdata : 32'h0;
        e_if_rv = 1'b0; e_if_rd = 32'h0;
        e_d_rv  = 1'b0; e_d_rd  = 32'h0;
        foreach (pend[k]) begin
            if (pend[k].due == cyc) begin
                if (pend[k].is_d) begin e_d_rv = 1'b1; e_d_rd = pend[k].data; end
                else begin e_if_rv = 1'b1; e_if_rd = pend[k].data; end
            end
        end
    endtask

    task automatic model_commit();
        rsp_t keep[$];
        if (rst) begin
            pend.delete();
            m_last_d = 1'b0;
        end else begin
            foreach (pend[k])
                if (pend[k].due > cyc && !(if_flush && !pend[k].is_d)) keep.push_back(pend[k]);
            pend = keep;
            if (e_en && !e_we) pend.push_back('{cyc + RL, e_d_gnt, ref_mem[e_addr[9:2]]});
            if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
            if (e_en) m_last_d = e_d_gnt;
        end
        cyc++;
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        advance();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; if_addr = 32'h8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
            advance();
        end
        rst = 1'b0; idle();
        @(negedge clk); model_eval(); total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, exp_vec()); end
        advance();
    endtask

    task automatic test_single_fetch();
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k == 0) begin if_req = 1'b1; if_addr = 32'h10; end
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL single_fetch cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k == 2) begin
                total++;
                if (!(if_rvalid === 1'b1 && if_rdata === ref_mem[4] && d_rvalid === 1'b0)) begin
                    bad++; $display("FAIL single_fetch_data got=%b/%h exp=1/%h", if_rvalid, if_rdata, ref_mem[4]);
                end
            end
            advance();
        end
    endtask

    task automatic test_contention();
        logic [3:0] order;
        idle();
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h40;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) idle();
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL contention cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k < 4) order[3-k] = d_gnt;
            advance();
            if (if_gnt) if_addr = if_addr + 32'h4;
            if (d_gnt)  d_addr  = d_addr + 32'h4;
        end
        total++;
        if (order !== 4'b1010) begin bad++; $display("FAIL contention_order got=%b exp=1010", order); end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) begin d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; end
            if (k == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0; end
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL write_read cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k == 3) begin
                total++;
                if (!(d_rvalid === 1'b1 && d_rdata === 32'hDEADBEEF)) begin
                    bad++; $display("FAIL raw_data got=%b/%h exp=1/deadbeef", d_rvalid, d_rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) begin if_req = 1'b1; if_addr = 32'h00; end
            if (k == 1) begin if_req = 1'b1; if_addr = 32'h04; if_flush = 1'b1; end
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL flush cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k == 2) begin
                total++;
                if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b exp=0", if_rvalid); end
            end
            if (k == 3) begin
                total++;
                if (!(if_rvalid === 1'b1 && if_rdata === ref_mem[1])) begin
                    bad++; $display("FAIL flush_redirect got=%b/%h exp=1/%h", if_rvalid, if_rdata, ref_mem[1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_isolation();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) begin d_req = 1'b1; d_addr = 32'h40; end
            if (k == 1) begin if_req = 1'b1; if_addr = 32'h20; if_flush = 1'b1; end
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL flush_iso cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k == 2) begin
                total++;
                if (!(d_rvalid === 1'b1 && d_rdata === ref_mem[16])) begin
                    bad++; $display("FAIL flush_iso_data got=%b/%h exp=1/%h", d_rvalid, d_rdata, ref_mem[16]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 7; k++) begin
            idle();
            if (k == 0) begin if_req = 1'b1; if_addr = 32'h30; end
            if (k == 1) begin d_req = 1'b1; d_addr = 32'h50; end
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
            if (k == 6) begin if_req = 1'b1; d_req = 1'b1; if_addr = 32'h60; d_addr = 32'h70; end
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k >= 3 && k <= 5) begin
                total++;
                if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_drop cyc=%0d got=%b exp=00", k, {if_rvalid, d_rvalid}); end
            end
            if (k == 6) begin
                total++;
                if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", {if_gnt, d_gnt}); end
            end
            advance();
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 49) == 0);
            if_req   = $urandom_range(0, 2) != 0;
            d_req    = $urandom_range(0, 2) != 0;
            d_we     = $urandom_range(0, 2) == 0;
            if_flush = $urandom_range(0, 7) == 0;
            if_addr  = $urandom;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            @(negedge clk); model_eval(); total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", k, obs, exp_vec()); end
            advance();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; m_last_d = 1'b0;
        rst = 1'b1; if_addr = '0; d_addr = '0; d_wdata = '0;
        idle();
        for (int i = 0; i < 256; i++) begin
            bram[i]    = 32'hA500_0000 ^ (i * 32'h0101_0301);
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0301);
        end
        test_reset();
        test_single_fetch();
        test_contention();
        test_write_read();
        test_flush();
        test_flush_isolation();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port program/data BRAM between the instruction-fetch port (IF) and the load/store port (D) of the processor.
- Issues at most one memory access per cycle, arbitrating round-robin under contention.
- Tracks in-flight reads through a tag pipeline matching the fixed memory read latency, and steers each read response back to the port that issued it.
- Supports a fetch flush on branch/jump redirect that discards stale in-flight fetch responses.

Parameters:
ADDR_W, 32, byte address width on all ports
DATA_W, 32, data width
READ_LAT, 2, cycles from mem_en (read) to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_flush  in  1  redirect pulse; kill in-flight fetch reads
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
d_rdata  out  DATA_W  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after a read strobe

Behaviour:
- Grant path (combinational from the request inputs and the last_owner flop):
  - Only one requester: that requester is granted in the same cycle.
  - Both requesting: grant the port that is not last_owner.
  - last_owner updates on every grant.
  - Reset value of last_owner = IF, so D wins the first contention.
- Memory drive on a grant:
  - mem_en = 1; mem_addr = mux of the granted port's address.
  - IF grant: mem_we = 0.
  - D grant: mem_we = d_we, mem_wdata = d_wdata.
  - No grant: mem_en = 0, mem_we = 0, mem_addr/mem_wdata = 0.
- While rst is high: if_gnt, d_gnt, mem_en and mem_we are forced to 0.
- Throughput and fairness:
  - One grant per cycle maximum; no bubbles inserted.
  - With both ports requesting continuously, grants strictly alternate. Starvation bound is 1 cycle.
- Tag pipeline:
  - READ_LAT stages, each holding {valid, owner}.
  - Stage 0 loads valid = (grant && !mem_we) and owner = granted port.
  - The pipeline shifts every cycle.
  - Writes create no tag and produce no response.
- Response:
  - if_rvalid = last stage valid && owner == IF.
  - d_rvalid = last stage valid && owner == D.
  - if_rdata and d_rdata both equal mem_rdata when their own rvalid is high, 0 otherwise.
  - Read latency from grant to rvalid is exactly READ_LAT cycles.
- if_flush:
  - Clears valid on every stage whose owner == IF, at the clock edge of the flush cycle.
  - A fetch granted in the same cycle as if_flush is not killed; it is the redirected fetch.
  - D tags are unaffected.
  - if_rvalid is not suppressed combinationally in the flush cycle: a response already at the last stage is still delivered.
- Read-after-write: a D read granted the cycle after a D write to the same address returns the written data. This is a memory property; the arbiter inserts no hazard logic.
- Reset:
  - All tag stages invalid; last_owner = IF.
  - if_rvalid/d_rvalid = 0 and rdata = 0 from the first cycle after the reset edge.
  - Reads in flight at reset are dropped and no response is delivered.
- Boundary: a requester dropping req without receiving gnt is legal; no state changes.

Test Plan:
- Reset then single fetch: if_req = 1, if_addr = 0x10 -> if_gnt same cycle, mem_en = 1, mem_addr = 0x10, mem_we = 0; if_rvalid = 1 exactly 2 cycles later with if_rdata = mem word at 0x10; d_rvalid stays 0.
- First contention after reset: if_req = d_req = 1 (d_we = 0, d_addr = 0x40) held 4 cycles with new addresses on each grant -> grant order D, IF, D, IF; each rvalid appears 2 cycles after its grant on the correct port.
- Write then read: d_req, d_we = 1, d_addr = 0x80, d_wdata = 0xDEADBEEF -> d_gnt, mem_we = 1, no d_rvalid from the write; next cycle a read of 0x80 -> d_rvalid 2 cycles later, d_rdata = 0xDEADBEEF.
- Flush: fetches at 0x00 (cycle 0) and 0x04 (cycle 1); if_flush = 1 in cycle 1 with fetch 0x04 granted -> the 0x00 response is killed (no if_rvalid in cycle 2); if_rvalid in cycle 3 with the 0x04 data.
- Flush isolation: D read granted in cycle 0, IF read in cycle 1, if_flush in cycle 1 -> d_rvalid still asserts in cycle 2 with the correct data.
- Reset mid-flight: reads granted in 2 consecutive cycles, rst = 1 in the next cycle -> no rvalid on either port afterwards; first post-reset contention grants D.
